// File: rtl/weight_loader_if.sv
// ============================================================================
// Module   : weight_loader_if
// Purpose  : Upstream valid/ready weight stream feeding weight_loader.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface weight_loader_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

`default_nettype wire

// File: rtl/weight_loader.sv
// ============================================================================
// Module   : weight_loader
// Purpose  : Streams kernel weights into NUM_BUF buffers, kernel_size words each.
//            Optional macro WLOAD_CFG_CHK_EN rejects bad configs instead of clamping.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module weight_loader #(
  parameter int DATA_WIDTH   = 16,
  parameter int BUFFER_DEPTH = 16,
  parameter int NUM_BUF      = 4
) (
  input  wire logic                  clk,
  input  wire logic                  rstn,
  input  wire logic                  i_start,
  input  wire logic [7:0]            i_kernel_size,
  input  wire logic [7:0]            i_num_buf,
  weight_loader_if.slave             s_if,
  output      logic [NUM_BUF-1:0]    o_flush,
  output      logic [DATA_WIDTH-1:0] o_data_out,
  output      logic                  o_busy,
  output      logic                  o_done,
  output      logic                  o_err
);

  localparam logic [7:0]         c_depth = 8'(BUFFER_DEPTH);
  localparam logic [7:0]         c_nbuf  = 8'(NUM_BUF);
  localparam logic [NUM_BUF-1:0] c_one   = NUM_BUF'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [7:0]            r_ks, w_ks_nxt;
  logic [7:0]            r_nb, w_nb_nxt;
  logic [7:0]            r_buf_idx, w_buf_idx_nxt;
  logic [7:0]            r_word_cnt, w_word_cnt_nxt;
  logic [NUM_BUF-1:0]    r_flush, w_flush_nxt;
  logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic                  r_err, w_err_nxt;

  logic       w_accept;
  logic       w_cfg_bad;
  logic [7:0] w_ks_cfg;
  logic [7:0] w_nb_cfg;

  assign s_if.s_ready = (r_state == S_LOAD);
  assign w_accept     = s_if.s_valid && (r_state == S_LOAD);

  assign o_flush    = r_flush;
  assign o_data_out = r_data;
  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = (r_state == S_DONE);
  assign o_err      = r_err;

  // Config sanitising: reject when checking is built in, otherwise clamp into range.
  always_comb begin
    w_ks_cfg  = i_kernel_size;
    w_nb_cfg  = i_num_buf;
    w_cfg_bad = 1'b0;
`ifdef WLOAD_CFG_CHK_EN
    w_cfg_bad = (i_kernel_size == 8'd0) || (i_kernel_size > c_depth) ||
                (i_num_buf == 8'd0)     || (i_num_buf > c_nbuf);
`else
    if (i_kernel_size == 8'd0)        w_ks_cfg = 8'd1;
    else if (i_kernel_size > c_depth) w_ks_cfg = c_depth;
    if (i_num_buf == 8'd0)            w_nb_cfg = 8'd1;
    else if (i_num_buf > c_nbuf)      w_nb_cfg = c_nbuf;
`endif
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ks_nxt       = r_ks;
    w_nb_nxt       = r_nb;
    w_buf_idx_nxt  = r_buf_idx;
    w_word_cnt_nxt = r_word_cnt;
    w_flush_nxt    = '0;
    w_data_nxt     = r_data;
    w_err_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (w_cfg_bad) begin
            w_err_nxt = 1'b1;
          end else begin
            w_state_nxt    = S_LOAD;
            w_ks_nxt       = w_ks_cfg;
            w_nb_nxt       = w_nb_cfg;
            w_buf_idx_nxt  = 8'd0;
            w_word_cnt_nxt = 8'd0;
          end
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          w_flush_nxt = c_one << r_buf_idx;
          w_data_nxt  = s_if.s_data;
          if (r_word_cnt == r_ks - 8'd1) begin
            w_word_cnt_nxt = 8'd0;
            if (r_buf_idx == r_nb - 8'd1) begin
              w_state_nxt = S_DONE;
            end else begin
              w_buf_idx_nxt = r_buf_idx + 8'd1;
              w_state_nxt   = S_GAP;
            end
          end else begin
            w_word_cnt_nxt = r_word_cnt + 8'd1;
          end
        end
      end
      // The gap forces one flush-low cycle between consecutive buffers.
      S_GAP:   w_state_nxt = S_LOAD;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_ks       <= 8'd0;
      r_nb       <= 8'd0;
      r_buf_idx  <= 8'd0;
      r_word_cnt <= 8'd0;
      r_flush    <= '0;
      r_data     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ks       <= w_ks_nxt;
      r_nb       <= w_nb_nxt;
      r_buf_idx  <= w_buf_idx_nxt;
      r_word_cnt <= w_word_cnt_nxt;
      r_flush    <= w_flush_nxt;
      r_data     <= w_data_nxt;
      r_err      <= w_err_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_weight_loader.sv
// ============================================================================
// Module   : tb_weight_loader
// Purpose  : Directed self-checking bench for weight_loader (NUM_BUF=4, 16-bit).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_weight_loader;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [7:0]  ks;
  logic [7:0]  nb;
  logic [3:0]  flush;
  logic [15:0] data_out;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  weight_loader_if #(.DATA_WIDTH(16)) s_if ();

  weight_loader #(
    .DATA_WIDTH  (16),
    .BUFFER_DEPTH(16),
    .NUM_BUF     (4)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_start      (start),
    .i_kernel_size(ks),
    .i_num_buf    (nb),
    .s_if         (s_if),
    .o_flush      (flush),
    .o_data_out   (data_out),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [23:0] got;
    rstn = 1'b0; start = 1'b0; ks = 8'd0; nb = 8'd0;
    s_if.s_valid = 1'b0; s_if.s_data = 16'd0;
    step; step;
    got = {s_if.s_ready, busy, done, err, flush, data_out};
    checks++;
    if (got !== 24'h0) begin
      errors++; $display("FAIL reset_outputs got %h want 000000", got);
    end
    rstn = 1'b1;
  endtask

  // ks=3, nb=2, s_valid constant, words 1..6; one row per edge after start is sampled.
  task automatic test_basic;
    int er [9]  = '{1,1,1,0,1,1,1,0,0};
    int eb [9]  = '{1,1,1,1,1,1,1,1,0};
    int edn[9]  = '{0,0,0,0,0,0,0,1,0};
    int ef [9]  = '{0,1,1,1,0,2,2,2,0};
    int ed [9]  = '{0,1,2,3,3,4,5,6,6};
    int drv[9]  = '{1,2,3,4,4,5,6,0,0};
    logic [23:0] got, want;
    start = 1'b1; ks = 8'd3; nb = 8'd2;
    s_if.s_valid = 1'b1; s_if.s_data = 16'd1;
    for (int i = 0; i < 9; i++) begin
      step;
      start = 1'b0;
      got  = {s_if.s_ready, busy, done, err, flush, data_out};
      want = {er[i][0], eb[i][0], edn[i][0], 1'b0, ef[i][3:0], ed[i][15:0]};
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL basic_cycle%0d got %h want %h", i, got, want);
      end
      s_if.s_data = drv[i][15:0];
    end
    s_if.s_valid = 1'b0;
  endtask

  task automatic test_stall;
    int acc = 0, dn = 0;
    bit pend = 1'b0, fin = 1'b0;
    logic [3:0]  pf = 4'd0, wf;
    logic [15:0] ld = 16'd6;
    start = 1'b1; ks = 8'd3; nb = 8'd2; s_if.s_valid = 1'b0;
    step;
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      wf = pend ? pf : 4'd0;
      checks++;
      if (flush !== wf || data_out !== ld || err !== 1'b0) begin
        errors++;
        $display("FAIL stall_cycle%0d got flush %h data %0d want flush %h data %0d", c, flush, data_out, wf, ld);
      end
      if (done) dn++;
      if (!busy) begin fin = 1'b1; break; end
      s_if.s_valid = (c % 2 == 1);
      s_if.s_data  = 16'(acc + 1);
      pend = s_if.s_valid && s_if.s_ready;
      if (pend) begin
        pf = (acc < 3) ? 4'b0001 : 4'b0010;
        ld = 16'(acc + 1);
        acc++;
      end
      step;
    end
    s_if.s_valid = 1'b0;
    checks++;
    if (!fin || acc != 6 || dn != 1) begin
      errors++; $display("FAIL stall_totals got fin %0d words %0d done %0d want 1 6 1", fin, acc, dn);
    end
  endtask

  // start re-asserted in LOAD (with a different config) and in the DONE cycle.
  task automatic test_start_ignored;
    int acc = 0, dn = 0;
    bit pend = 1'b0, fin = 1'b0;
    logic [3:0]  pf = 4'd0, wf;
    logic [15:0] ld = 16'd6;
    start = 1'b1; ks = 8'd3; nb = 8'd2; s_if.s_valid = 1'b0;
    step;
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      wf = pend ? pf : 4'd0;
      checks++;
      if (flush !== wf || data_out !== ld) begin
        errors++;
        $display("FAIL restart_cycle%0d got flush %h data %0d want flush %h data %0d", c, flush, data_out, wf, ld);
      end
      if (done) dn++;
      if (!busy) begin fin = 1'b1; break; end
      start = (c == 2) || done;
      ks = 8'd1; nb = 8'd1;
      s_if.s_valid = 1'b1;
      s_if.s_data  = 16'(acc + 1);
      pend = s_if.s_valid && s_if.s_ready;
      if (pend) begin
        pf = (acc < 3) ? 4'b0001 : 4'b0010;
        ld = 16'(acc + 1);
        acc++;
      end
      step;
    end
    start = 1'b0;
    step;
    checks++;
    if (!fin || acc != 6 || dn != 1 || busy !== 1'b0 || s_if.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL restart_totals got fin %0d words %0d done %0d busy %b want 1 6 1 0", fin, acc, dn, busy);
    end
    s_if.s_valid = 1'b0;
  endtask

  task automatic test_reset_midload;
    int er [4] = '{1,1,0,0};
    int eb [4] = '{1,1,1,0};
    int edn[4] = '{0,0,1,0};
    int ef [4] = '{0,1,1,0};
    int ed [4] = '{0,7,8,8};
    int drv[4] = '{7,8,0,0};
    logic [23:0] got, want;
    start = 1'b1; ks = 8'd3; nb = 8'd2;
    s_if.s_valid = 1'b1; s_if.s_data = 16'd1;
    step;
    start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step;
      s_if.s_data = (i < 3) ? 16'(i + 1) : 16'(i);
    end
    checks++;
    if (flush !== 4'b0010 || data_out !== 16'd5) begin
      errors++; $display("FAIL midload_pre got flush %h data %0d want 2 5", flush, data_out);
    end
    rstn = 1'b0;
    #1;
    got = {s_if.s_ready, busy, done, err, flush, data_out};
    checks++;
    if (got !== 24'h0) begin
      errors++; $display("FAIL midload_reset got %h want 000000", got);
    end
    #2;
    rstn = 1'b1;
    start = 1'b1; ks = 8'd2; nb = 8'd1; s_if.s_data = 16'd7;
    for (int i = 0; i < 4; i++) begin
      step;
      start = 1'b0;
      got  = {s_if.s_ready, busy, done, err, flush, data_out};
      want = {er[i][0], eb[i][0], edn[i][0], 1'b0, ef[i][3:0], ed[i][15:0]};
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL fresh_cycle%0d got %h want %h", i, got, want);
      end
      s_if.s_data = drv[i][15:0];
    end
    s_if.s_valid = 1'b0;
  endtask

`ifdef WLOAD_CFG_CHK_EN
  task automatic test_cfg_check;
    int kk[3] = '{0,17,3};
    int nn[3] = '{2,2,5};
    logic [2:0] got;
    s_if.s_valid = 1'b1; s_if.s_data = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; ks = kk[i][7:0]; nb = nn[i][7:0];
      step;
      start = 1'b0;
      got = {s_if.s_ready, busy, err};
      checks++;
      if (got !== 3'b001) begin
        errors++; $display("FAIL cfg%0d_pulse got %b want 001", i, got);
      end
      step;
      got = {s_if.s_ready, busy, err};
      checks++;
      if (got !== 3'b000 || flush !== 4'd0) begin
        errors++; $display("FAIL cfg%0d_after got %b flush %h want 000 0", i, got, flush);
      end
    end
    s_if.s_valid = 1'b0;
  endtask
`else
  // ks=20, nb=9 clamp to 16 words x 4 buffers.
  task automatic test_clamp;
    int acc = 0, dn = 0;
    bit pend = 1'b0, fin = 1'b0;
    logic [3:0]  pf = 4'd0, wf;
    logic [15:0] ld = 16'd8;
    start = 1'b1; ks = 8'd20; nb = 8'd9; s_if.s_valid = 1'b0;
    step;
    start = 1'b0;
    for (int c = 0; c < 120; c++) begin
      wf = pend ? pf : 4'd0;
      checks++;
      if (flush !== wf || data_out !== ld || err !== 1'b0) begin
        errors++;
        $display("FAIL clamp_cycle%0d got flush %h data %0d err %b want flush %h data %0d err 0", c, flush, data_out, err, wf, ld);
      end
      if (done) dn++;
      if (!busy) begin fin = 1'b1; break; end
      s_if.s_valid = 1'b1;
      s_if.s_data  = 16'(acc + 1);
      pend = s_if.s_valid && s_if.s_ready;
      if (pend) begin
        pf = 4'(1 << (acc / 16));
        ld = 16'(acc + 1);
        acc++;
      end
      step;
    end
    s_if.s_valid = 1'b0;
    checks++;
    if (!fin || acc != 64 || dn != 1) begin
      errors++; $display("FAIL clamp_totals got fin %0d words %0d done %0d want 1 64 1", fin, acc, dn);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_start_ignored;
    test_reset_midload;
`ifdef WLOAD_CFG_CHK_EN
    test_cfg_check;
`else
    test_clamp;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
